// File: rtl/fir_filter_param.sv
// Parametrised signed streaming FIR: delay line, registered products, registered sum,
// then optional integration, round-half-up scaling and saturation to DATA_W.
module fir_filter_param #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int TAPS      = 4,
  parameter int OUT_SHIFT = 6,
  parameter int ACC_EXT   = 8,
  localparam int ADDR_W   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              mode,
  input  logic              acc_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);

  localparam int P_W = DATA_W + COEF_W;
  localparam int S_W = P_W + $clog2(TAPS);
  localparam int A_W = S_W + ACC_EXT;
  // One extra bit so adding the rounding constant can never wrap.
  localparam int R_W = A_W + 1;

  localparam logic signed [R_W-1:0]    ROUND = R_W'(1) << (OUT_SHIFT - 1);
  localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [R_W-1:0]    MAX_R = R_W'(MAX_D);
  localparam logic signed [R_W-1:0]    MIN_R = R_W'(MIN_D);

  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] h [TAPS];
  logic signed [P_W-1:0]    p [TAPS];
  logic signed [S_W-1:0]    sum;
  logic signed [S_W-1:0]    sum_comb;
  logic signed [A_W-1:0]    acc;
  logic signed [A_W-1:0]    acc_next;
  logic signed [A_W-1:0]    v;
  logic signed [R_W-1:0]    r;
  logic signed [DATA_W-1:0] y;
  logic                     sat;
  logic                     valid_x;
  logic                     valid_p;
  logic                     valid_s;

  always_comb begin
    sum_comb = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_comb = sum_comb + S_W'(p[k]);
    end
  end

  // Clear wins over integration but still loads the current sum; an idle clear zeroes acc.
  always_comb begin
    acc_next = acc;
    v        = A_W'(sum);
    if (valid_s) begin
      if (acc_clr) begin
        acc_next = A_W'(sum);
      end else if (mode) begin
        acc_next = acc + A_W'(sum);
      end
      if (mode) begin
        v = acc_next;
      end
    end else if (acc_clr) begin
      acc_next = '0;
    end
  end

  always_comb begin
    r   = (R_W'(v) + ROUND) >>> OUT_SHIFT;
    y   = r[DATA_W-1:0];
    sat = 1'b0;
    if (r > MAX_R) begin
      y   = MAX_D;
      sat = 1'b1;
    end else if (r < MIN_R) begin
      y   = MIN_D;
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        h[k] <= '0;
        p[k] <= '0;
      end
      sum       <= '0;
      acc       <= '0;
      valid_x   <= 1'b0;
      valid_p   <= 1'b0;
      valid_s   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (in_valid) begin
        x[0] <= in_data;
        for (int k = 1; k < TAPS; k++) begin
          x[k] <= x[k-1];
        end
      end
      if (coef_we && (int'(coef_addr) < TAPS)) begin
        h[coef_addr] <= coef_data;
      end
      for (int k = 0; k < TAPS; k++) begin
        p[k] <= P_W'(x[k]) * P_W'(h[k]);
      end
      sum       <= sum_comb;
      acc       <= acc_next;
      valid_x   <= in_valid;
      valid_p   <= valid_x;
      valid_s   <= valid_p;
      out_valid <= valid_s;
      out_sat   <= valid_s & sat;
      if (valid_s) begin
        out_data <= y;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param: a reference model pushes expected outputs with their
// due cycle into a scoreboard queue; a negedge monitor pops and checks value, saturation and timing.
module tb_fir_filter_param;

  localparam int DATA_W    = 8;
  localparam int COEF_W    = 8;
  localparam int TAPS      = 4;
  localparam int OUT_SHIFT = 6;
  localparam int ACC_EXT   = 8;
  localparam int A_W       = DATA_W + COEF_W + 2 + ACC_EXT;

  typedef struct {
    longint data;
    logic   sat;
    longint due;
    string  tag;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              mode;
  logic              acc_clr;
  logic              out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic              out_sat;

  int     total;
  int     passes;
  int     fails;
  longint cyc;
  exp_t   sb[$];
  longint mx[TAPS];
  longint mh[TAPS];
  longint macc;
  bit     clr_hist[3];

  fir_filter_param #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_SHIFT(OUT_SHIFT), .ACC_EXT(ACC_EXT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mode(mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint rand8();
    logic signed [7:0] t;
    t = 8'($urandom);
    return t;
  endfunction

  // Expected result of one accepted sample, following the arithmetic description directly.
  task automatic pushExpected(input bit clr, input string tag);
    longint s, v, r;
    logic signed [A_W-1:0] a;
    exp_t e;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += mx[k] * mh[k];
    v = s;
    if (clr) macc = s;
    else if (mode) begin
      a = A_W'(macc + s);
      macc = longint'(a);
    end
    if (mode) v = macc;
    r = (v + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
    e.sat = 1'b0;
    if (r > 127) begin r = 127; e.sat = 1'b1; end
    else if (r < -128) begin r = -128; e.sat = 1'b1; end
    e.data = r;
    e.due  = cyc + 3;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // One clock of stimulus; acc_clr is replayed three cycles later to meet its sample at stage 3.
  task automatic applyStimulus(input bit v, input longint d, input bit clr,
                               input bit we = 1'b0, input int addr = 0, input longint cd = 0,
                               input string tag = "smp");
    acc_clr   = clr_hist[2];
    in_valid  = v;
    in_data   = DATA_W'(d);
    coef_we   = we;
    coef_addr = 2'(addr);
    coef_data = COEF_W'(cd);
    @(posedge clk);
    #1;
    if (we) mh[addr] = cd;
    if (v) begin
      for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = d;
      pushExpected(clr, tag);
    end
    clr_hist[2] = clr_hist[1];
    clr_hist[1] = clr_hist[0];
    clr_hist[0] = v & clr;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) applyStimulus(1'b0, 0, 1'b0);
  endtask

  // Reset with every other control asserted, proving reset takes priority.
  task automatic applyReset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'd77;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd5; acc_clr = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0; coef_we = 1'b0; acc_clr = 1'b0;
    sb.delete();
    for (int k = 0; k < TAPS; k++) begin mx[k] = 0; mh[k] = 0; end
    macc = 0;
    for (int k = 0; k < 3; k++) clr_hist[k] = 1'b0;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_sat", out_sat, 0);
  endtask

  task automatic loadCoefs(input longint c0, input longint c1, input longint c2, input longint c3);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 0, c0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1, c1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 2, c2);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 3, c3);
  endtask

  task automatic idleClear();
    drain(4);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    macc = 0;
  endtask

  // Scoreboard monitor: every out_valid must match the queue head on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", out_valid, 0);
      end else begin
        e = sb.pop_front();
        checkOutput({e.tag, "_cycle"}, cyc, e.due);
        checkOutput({e.tag, "_data"}, out_data, e.data);
        checkOutput({e.tag, "_sat"}, out_sat, e.sat);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkOutput({e.tag, "_missing_valid"}, out_valid, 1);
    end
  end

  initial begin
    total = 0; passes = 0; fails = 0; macc = 0;
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
    coef_addr = '0; coef_data = '0; mode = 1'b0; acc_clr = 1'b0;
    for (int k = 0; k < TAPS; k++) begin mx[k] = 0; mh[k] = 0; end
    for (int k = 0; k < 3; k++) clr_hist[k] = 1'b0;
    @(negedge clk);
    applyReset();

    // Coefficients are zero straight after reset.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 100, 1'b0, 1'b0, 0, 0, "nocoef");
    drain(4);

    loadCoefs(6, 28, 28, 6);
    applyStimulus(1'b1, 64, 1'b0, 1'b0, 0, 0, "impulse");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 1'b0, 1'b0, 0, 0, "impulse");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 100, 1'b0, 1'b0, 0, 0, "step");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 127, 1'b0, 1'b0, 0, 0, "satpos");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, -128, 1'b0, 1'b0, 0, 0, "satneg");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 1'b0, 1'b0, 0, 0, "flush");
    drain(4);

    // Integrating mode, then grow past full scale.
    mode = 1'b1;
    idleClear();
    applyStimulus(1'b1, 64, 1'b0, 1'b0, 0, 0, "integ");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0, 1'b0, 1'b0, 0, 0, "integ");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 100, 1'b0, 1'b0, 0, 0, "integsat");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 1'b0, 1'b0, 0, 0, "integsat");
    idleClear();
    applyStimulus(1'b1, 64, 1'b0, 1'b0, 0, 0, "integclr");
    applyStimulus(1'b1, 0, 1'b1, 1'b0, 0, 0, "integclr");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 1'b0, 1'b0, 0, 0, "integclr");
    drain(4);
    mode = 1'b0;

    // Idle coefficient update, then gapped impulse.
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 0, -6);
    applyStimulus(1'b1, 64, 1'b0, 1'b0, 0, 0, "gap");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 0, 1'b0);
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 0, 0, "gap");
    end
    drain(4);

    // Signed random stream with random coefficients.
    loadCoefs(rand8(), rand8(), rand8(), rand8());
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, rand8(), 1'b0, 1'b0, 0, 0, "rand");
    drain(4);

    // Mid-stream reset discards in-flight samples and clears coefficients.
    loadCoefs(6, 28, 28, 6);
    applyStimulus(1'b1, 50, 1'b0, 1'b0, 0, 0, "prerst");
    applyStimulus(1'b1, -30, 1'b0, 1'b0, 0, 0, "prerst");
    applyStimulus(1'b1, 90, 1'b0, 1'b0, 0, 0, "prerst");
    applyStimulus(1'b1, 10, 1'b0, 1'b0, 0, 0, "prerst");
    applyReset();
    drain(6);
    applyStimulus(1'b1, 64, 1'b0, 1'b0, 0, 0, "postrst");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 1'b0, 1'b0, 0, 0, "postrst");

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      drain(1);
    end
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
